uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 134 +++++++++++++
 tb/tb_uart_tx.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-entry holding register in front of the shift register.
// A byte waiting in the holding register is launched straight out of the stop bit.
module uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic       i_fpga_clk,
   input  logic       i_rst,
   input  logic [7:0] i_tx_data,
   input  logic       i_tx_valid,
   output logic       o_tx_ready,
   output logic       o_uart_txd,
   output logic       o_tx_busy,
   output logic       o_tx_done
);

   localparam int unsigned CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] PRE_LAST_CNT = CW'(CLKS_PER_BIT - 2);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e        r_state;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_bit;
   logic [7:0]    r_shift;
   logic [7:0]    r_hold;
   logic          r_hold_full;
   logic          r_txd;
   logic          r_busy;
   logic          r_done;

   logic w_bit_end;
   logic w_accept;
   logic w_load;

   assign w_bit_end = (r_cnt == LAST_CNT);
   assign w_accept  = i_tx_valid & ~r_hold_full;
   // Holding register drains when idle, or on the final stop cycle for gapless frames.
   assign w_load    = r_hold_full &
                      ((r_state == StIdle) | ((r_state == StStop) & w_bit_end));

   assign o_tx_ready = ~r_hold_full;
   assign o_uart_txd = r_txd;
   assign o_tx_busy  = r_busy;
   assign o_tx_done  = r_done;

   always_ff @(posedge i_fpga_clk or posedge i_rst) begin
      if (i_rst) begin
         r_hold_full <= 1'b0;
         r_hold      <= 8'h00;
      end else begin
         if (w_load) begin
            r_hold_full <= 1'b0;
         end
         if (w_accept) begin
            r_hold_full <= 1'b1;
            r_hold      <= i_tx_data;
         end
      end
   end

   always_ff @(posedge i_fpga_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= StIdle;
         r_cnt   <= '0;
         r_bit   <= 3'd0;
         r_shift <= 8'h00;
         r_txd   <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (w_load) begin
                  r_state <= StStart;
                  r_shift <= r_hold;
                  r_cnt   <= '0;
                  r_txd   <= 1'b0;
                  r_busy  <= 1'b1;
               end
            end
            StStart: begin
               if (w_bit_end) begin
                  r_state <= StData;
                  r_cnt   <= '0;
                  r_bit   <= 3'd0;
                  r_txd   <= r_shift[0];
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            StData: begin
               if (w_bit_end) begin
                  r_cnt <= '0;
                  if (r_bit == 3'd7) begin
                     r_state <= StStop;
                     r_txd   <= 1'b1;
                  end else begin
                     r_bit   <= r_bit + 3'd1;
                     r_shift <= {1'b0, r_shift[7:1]};
                     r_txd   <= r_shift[1];
                  end
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            StStop: begin
               // Registered pulse lands on the last stop cycle.
               if (r_cnt == PRE_LAST_CNT) begin
                  r_done <= 1'b1;
               end
               if (w_bit_end) begin
                  r_cnt <= '0;
                  if (r_hold_full) begin
                     r_state <= StStart;
                     r_shift <= r_hold;
                     r_txd   <= 1'b0;
                  end else begin
                     r_state <= StIdle;
                     r_busy  <= 1'b0;
                  end
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a frame-queue model checked every cycle, pinned by hand-computed
// waveform points, plus a bit-timing measurement on a 434-clock instance.
module tb_uart_tx;

   localparam int unsigned Cpb = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic       txd;
   logic       busy;
   logic       done;

   logic [7:0] tx_data2 = 8'h00;
   logic       tx_valid2 = 1'b0;
   logic       tx_ready2;
   logic       txd2;
   logic       busy2;
   logic       done2;

   int n_chk = 0;
   int n_err = 0;
   int t0 = 0;

   // Model state: future line samples of the frame in flight, and the held byte.
   bit         m_line[$];
   logic [7:0] m_hold[$];
   logic       m_txd = 1'b1;
   logic       m_busy = 1'b0;
   logic       m_done = 1'b0;
   logic       m_ready = 1'b1;
   logic       m_acc = 1'b0;
   int         cyc = 0;

   always #5 clk = ~clk;

   uart_tx #(.CLKS_PER_BIT(Cpb)) u_dut (
      .i_fpga_clk(clk),
      .i_rst     (rst),
      .i_tx_data (tx_data),
      .i_tx_valid(tx_valid),
      .o_tx_ready(tx_ready),
      .o_uart_txd(txd),
      .o_tx_busy (busy),
      .o_tx_done (done)
   );

   uart_tx #(.CLKS_PER_BIT(434)) u_dut434 (
      .i_fpga_clk(clk),
      .i_rst     (rst),
      .i_tx_data (tx_data2),
      .i_tx_valid(tx_valid2),
      .o_tx_ready(tx_ready2),
      .o_uart_txd(txd2),
      .o_tx_busy (busy2),
      .o_tx_done (done2)
   );

   always @(posedge clk or posedge rst) begin : model
      logic [7:0] b;
      if (rst) begin
         m_line.delete();
         m_hold.delete();
         m_txd   = 1'b1;
         m_busy  = 1'b0;
         m_done  = 1'b0;
         m_ready = 1'b1;
         m_acc   = 1'b0;
      end else begin
         cyc++;
         m_acc = tx_valid && (m_hold.size() == 0);
         if (m_line.size() == 0 && m_hold.size() != 0) begin
            b = m_hold.pop_front();
            for (int i = 0; i < 10; i++) begin
               bit v;
               v = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1];
               repeat (Cpb) m_line.push_back(v);
            end
         end
         if (m_line.size() != 0) begin
            m_txd  = m_line.pop_front();
            m_busy = 1'b1;
            m_done = (m_line.size() == 0);
         end else begin
            m_txd  = 1'b1;
            m_busy = 1'b0;
            m_done = 1'b0;
         end
         if (m_acc) m_hold.push_back(tx_data);
         m_ready = (m_hold.size() == 0);
      end
   end

   task automatic cmp(input string nm, input logic [3:0] act, input logic [3:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cycle %0d: txd/busy/done/ready got %b required %b", nm, cyc, act,
                  exp);
      end
   endtask

   task automatic compare_loop();
      forever begin
         @(negedge clk);
         if (!rst) cmp("per-cycle", {txd, busy, done, tx_ready}, {m_txd, m_busy, m_done, m_ready});
      end
   endtask

   task automatic pin(input string nm, input int k, input logic [3:0] exp);
      while (cyc < t0 + k) @(negedge clk);
      cmp({nm, " model"}, {m_txd, m_busy, m_done, m_ready}, exp);
      cmp({nm, " dut"}, {txd, busy, done, tx_ready}, exp);
   endtask

   task automatic send(input logic [7:0] b, input bit keep);
      int n;
      tx_valid = 1'b1;
      tx_data  = b;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!m_acc && n < 200);
      n_chk++;
      if (!m_acc) begin
         n_err++;
         $display("FAIL handshake byte %h: not accepted after %0d cycles, required accept", b, n);
      end
      if (!keep) begin
         tx_valid = 1'b0;
         tx_data  = 8'($urandom);
      end
   endtask

   task automatic run434();
      logic [7:0] d55;
      int         bad[10];
      int         busy_bad;
      int         dcnt;
      int         dpos;
      int         idx;
      logic       v;
      d55 = 8'h55;
      busy_bad = 0;
      dcnt = 0;
      dpos = 0;
      for (int i = 0; i < 10; i++) bad[i] = 0;
      @(negedge clk);
      tx_valid2 = 1'b1;
      tx_data2  = d55;
      @(posedge clk);
      #1;
      n_chk++;
      if (tx_ready2 !== 1'b0) begin
         n_err++;
         $display("FAIL accept434: ready got %b required 0", tx_ready2);
      end
      tx_valid2 = 1'b0;
      tx_data2  = 8'hFF;
      for (int j = 1; j <= 4340; j++) begin
         @(posedge clk);
         #2;
         idx = (j - 1) / 434;
         v = (idx == 0) ? 1'b0 : (idx == 9) ? 1'b1 : d55[idx-1];
         if (txd2 !== v) bad[idx]++;
         if (busy2 !== 1'b1) busy_bad++;
         if (done2 === 1'b1) begin
            dcnt++;
            dpos = j;
         end
      end
      for (int i = 0; i < 10; i++) begin
         n_chk++;
         if (bad[i] != 0) begin
            n_err++;
            $display("FAIL bit434 %0d: %0d wrong cycles, required 0", i, bad[i]);
         end
      end
      n_chk++;
      if (busy_bad != 0) begin
         n_err++;
         $display("FAIL busy434: %0d low cycles in frame, required 0", busy_bad);
      end
      n_chk++;
      if (dcnt != 1 || dpos != 4340) begin
         n_err++;
         $display("FAIL done434: %0d pulses last at %0d, required 1 at 4340", dcnt, dpos);
      end
      @(posedge clk);
      #2;
      n_chk++;
      if ({txd2, busy2, done2, tx_ready2} !== 4'b1001) begin
         n_err++;
         $display("FAIL idle434: got %b required 1001", {txd2, busy2, done2, tx_ready2});
      end
   endtask

   initial begin
      fork
         compare_loop();
      join_none

      #1 rst = 1'b1;
      #1;
      cmp("reset", {txd, busy, done, tx_ready}, 4'b1001);
      cmp("reset434", {txd2, busy2, done2, tx_ready2}, 4'b1001);
      repeat (2) @(negedge clk);
      #1 rst = 1'b0;
      repeat (3) @(negedge clk);

      // Single byte 0xA5
      t0 = cyc + 1;
      fork
         send(8'hA5, 1'b0);
         begin
            pin("a5 held", 0, 4'b1000);
            pin("a5 start", 1, 4'b0101);
            pin("a5 start end", 4, 4'b0101);
            pin("a5 d0", 5, 4'b1101);
            pin("a5 d1", 9, 4'b0101);
            pin("a5 d4", 21, 4'b0101);
            pin("a5 d7", 33, 4'b1101);
            pin("a5 stop", 37, 4'b1101);
            pin("a5 done", 40, 4'b1111);
            pin("a5 idle", 41, 4'b1001);
         end
      join
      repeat (3) @(negedge clk);

      // Back-to-back 0x00, 0xFF
      t0 = cyc + 1;
      fork
         begin
            send(8'h00, 1'b1);
            send(8'hFF, 1'b0);
         end
         begin
            pin("b2b ready", 1, 4'b0101);
            pin("b2b held", 2, 4'b0100);
            pin("b2b d7", 36, 4'b0100);
            pin("b2b done", 40, 4'b1110);
            pin("b2b start2", 41, 4'b0101);
            pin("b2b ff d0", 45, 4'b1101);
            pin("b2b idle", 81, 4'b1001);
         end
      join
      repeat (3) @(negedge clk);

      // Backpressure 0x11, 0x22, 0x33
      t0 = cyc + 1;
      fork
         begin
            send(8'h11, 1'b1);
            send(8'h22, 1'b1);
            send(8'h33, 1'b0);
         end
         begin
            pin("bp held", 2, 4'b0100);
            pin("bp done1", 40, 4'b1110);
            pin("bp start2", 41, 4'b0101);
            pin("bp held3", 42, 4'b0100);
            pin("bp 22 d0", 45, 4'b0100);
            pin("bp 22 d1", 49, 4'b1100);
            pin("bp done2", 80, 4'b1110);
            pin("bp start3", 81, 4'b0101);
            pin("bp 33 d0", 85, 4'b1101);
            pin("bp 33 d2", 93, 4'b0101);
            pin("bp done3", 120, 4'b1111);
            pin("bp idle", 121, 4'b1001);
         end
      join
      repeat (3) @(negedge clk);

      // Reset during D3 of 0x5A with 0x77 held
      t0 = cyc + 1;
      fork
         begin
            send(8'h5A, 1'b0);
            send(8'h77, 1'b0);
         end
         begin
            pin("rst d2", 13, 4'b0100);
            pin("rst d3", 18, 4'b1100);
         end
      join
      #1 rst = 1'b1;
      #1;
      cmp("async reset dut", {txd, busy, done, tx_ready}, 4'b1001);
      cmp("async reset model", {m_txd, m_busy, m_done, m_ready}, 4'b1001);
      tx_valid = 1'b1;
      tx_data  = 8'hEE;
      repeat (3) @(posedge clk);
      #1 tx_valid = 1'b0;
      @(negedge clk);
      #1 rst = 1'b0;
      repeat (20) @(negedge clk);
      cmp("post-reset idle", {txd, busy, done, tx_ready}, 4'b1001);
      @(negedge clk);
      t0 = cyc + 1;
      fork
         send(8'h3C, 1'b0);
         begin
            pin("3c start", 1, 4'b0101);
            pin("3c d0", 5, 4'b0101);
            pin("3c d2", 13, 4'b1101);
            pin("3c done", 40, 4'b1111);
            pin("3c idle", 41, 4'b1001);
         end
      join

      // Data toggling without valid
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         tx_data = 8'($urandom);
      end
      @(negedge clk);
      cmp("toggle idle", {txd, busy, done, tx_ready}, 4'b1001);

      run434();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
